// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard scoreboard.
//   sb_entry_t     : one in-flight pipeline stage record
//   FWD_RF         : forwarding-select value meaning "read the register file"
//   REG_ZERO       : hard-wired zero register address
//   *_DEF          : default geometry used by the scoreboard parameters
// The rd field is sized for the widest supported register address and is
// zero-extended from REG_AW, so one struct type serves every configuration.
package pipe_pkg;

    localparam int unsigned NUM_STAGES_DEF = 3;
    localparam int unsigned REG_AW_DEF     = 5;
    localparam int unsigned REG_AW_MAX     = 8;
    localparam int unsigned FWD_RF         = 0;
    localparam int unsigned REG_ZERO       = 0;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  regwr;
        logic                  memrd;
        logic                  rpzero;
    } sb_entry_t;

    // An entry really produces a register value only when all of these hold.
    function automatic logic entry_writes(input sb_entry_t e);
        return e.valid & e.regwr & ~e.rpzero;
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Per-operand producer search for the hazard scoreboard.
// Ports:
//   src_addr_i    : source register address of this operand
//   src_used_i    : operand is actually read by the ID instruction
//   stages_i      : scoreboard entries, index 0 = stage 1 (EX) ... NUM_STAGES-1 = WB
//   hit_o         : some stage produces this operand
//   sel_o         : forwarding select (FWD_RF or stage number of the youngest producer)
//   is_load_hit_o : the winning producer is a load whose data is not yet on a bus
module hazard_src_match
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
    parameter int unsigned REG_AW     = REG_AW_DEF,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic [REG_AW-1:0] src_addr_i,
    input  logic              src_used_i,
    input  sb_entry_t         stages_i [NUM_STAGES],
    output logic              hit_o,
    output logic [SEL_W-1:0]  sel_o,
    output logic              is_load_hit_o
);

    logic [REG_AW_MAX-1:0] addr_ext;

    assign addr_ext = REG_AW_MAX'(src_addr_i);

    always_comb begin
        hit_o         = 1'b0;
        sel_o         = SEL_W'(FWD_RF);
        is_load_hit_o = 1'b0;
        if (src_used_i && (addr_ext != REG_AW_MAX'(REG_ZERO))) begin
            // Walk from oldest to youngest so the youngest match is the last write.
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                if (entry_writes(stages_i[NUM_STAGES-1-k]) &&
                    (stages_i[NUM_STAGES-1-k].rd == addr_ext)) begin
                    hit_o         = 1'b1;
                    sel_o         = SEL_W'(NUM_STAGES - k);
                    is_load_hit_o = stages_i[NUM_STAGES-1-k].memrd &&
                                    ((NUM_STAGES - k) < LOAD_STAGE);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker beside the ID stage.
// Records each issued instruction's destination as it moves down the pipe and
// derives per-operand forwarding selects, the load-use stall and the gated WB
// register-file write enable.
// Ports:
//   clk, rst_sync      : clock, asynchronous active-high reset
//   issue_*            : ID instruction (valid, rd, regwr, memrd, rpzero)
//   src_addr, src_used : packed source operands, operand i at [i*REG_AW +: REG_AW]
//   stall              : hold PC and IF/ID, bubble into stage 1
//   fwd_sel            : per-operand select, 0 = register file, k = stage-k bus
//   stage_valid        : occupancy of each tracked stage
//   wb_we, wb_rd       : gated register-file write for stage NUM_STAGES
// Optional (HAZARD_PERF_CNT_EN): stall_cycles, fwd_events saturating counters.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned REG_AW     = REG_AW_DEF,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                       clk,
    input  logic                       rst_sync,
    input  logic                       issue_valid,
    input  logic [REG_AW-1:0]          issue_rd,
    input  logic                       issue_regwr,
    input  logic                       issue_memrd,
    input  logic                       issue_rpzero,
    input  logic [NUM_SRC*REG_AW-1:0]  src_addr,
    input  logic [NUM_SRC-1:0]         src_used,
    output logic                       stall,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic [NUM_STAGES-1:0]      stage_valid,
    output logic                       wb_we,
    output logic [REG_AW-1:0]          wb_rd
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]                stall_cycles,
    output logic [31:0]                fwd_events
`endif
);

    sb_entry_t          stages_q [NUM_STAGES];
    sb_entry_t          stages_d [NUM_STAGES];
    logic [NUM_SRC-1:0] hit;
    logic [NUM_SRC-1:0] load_hit;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_src_match #(
            .NUM_STAGES (NUM_STAGES),
            .REG_AW     (REG_AW),
            .LOAD_STAGE (LOAD_STAGE),
            .SEL_W      (SEL_W)
        ) u_match (
            .src_addr_i    (src_addr[i*REG_AW +: REG_AW]),
            .src_used_i    (src_used[i]),
            .stages_i      (stages_q),
            .hit_o         (hit[i]),
            .sel_o         (fwd_sel[i*SEL_W +: SEL_W]),
            .is_load_hit_o (load_hit[i])
        );
    end

    assign stall = issue_valid & (|(hit & load_hit));

    // Pipe never freezes: a stall only replaces the new stage-1 entry with a bubble.
    always_comb begin
        stages_d[0] = '0;
        if (issue_valid && !stall) begin
            stages_d[0].valid  = 1'b1;
            stages_d[0].rd     = REG_AW_MAX'(issue_rd);
            stages_d[0].regwr  = issue_regwr;
            stages_d[0].memrd  = issue_memrd;
            stages_d[0].rpzero = issue_rpzero;
        end
        for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            stages_d[k] = stages_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                stages_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                stages_q[k] <= stages_d[k];
            end
        end
    end

    always_comb begin
        stage_valid = '0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            stage_valid[k] = stages_q[k].valid;
        end
    end

    assign wb_we = entry_writes(stages_q[NUM_STAGES-1]) &&
                   (stages_q[NUM_STAGES-1].rd != REG_AW_MAX'(REG_ZERO));
    assign wb_rd = stages_q[NUM_STAGES-1].rd[REG_AW-1:0];

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] fwd_events_q, fwd_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        fwd_events_d   = fwd_events_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        // A nonzero select is exactly an operand with a producer hit.
        if (issue_valid && !stall && (|hit) && (fwd_events_q != '1)) begin
            fwd_events_d = fwd_events_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            stall_cycles_q <= '0;
            fwd_events_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            fwd_events_q   <= fwd_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign fwd_events   = fwd_events_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazard scenarios followed
// by randomized issue traffic, all compared against a stage-array reference model.
module tb_hazard_scoreboard;

    localparam int NST  = 3;
    localparam int NSRC = 3;
    localparam int AW   = 5;
    localparam int LDS  = 2;
    localparam int SW   = 2;

    logic                 clk;
    logic                 rst_sync;
    logic                 issue_valid;
    logic [AW-1:0]        issue_rd;
    logic                 issue_regwr;
    logic                 issue_memrd;
    logic                 issue_rpzero;
    logic [NSRC*AW-1:0]   src_addr;
    logic [NSRC-1:0]      src_used;
    logic                 stall;
    logic [NSRC*SW-1:0]   fwd_sel;
    logic [NST-1:0]       stage_valid;
    logic                 wb_we;
    logic [AW-1:0]        wb_rd;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]          stall_cycles;
    logic [31:0]          fwd_events;
`endif

    hazard_scoreboard #(
        .NUM_STAGES (NST),
        .NUM_SRC    (NSRC),
        .REG_AW     (AW),
        .LOAD_STAGE (LDS),
        .SEL_W      (SW)
    ) dut (
        .clk          (clk),
        .rst_sync     (rst_sync),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_regwr  (issue_regwr),
        .issue_memrd  (issue_memrd),
        .issue_rpzero (issue_rpzero),
        .src_addr     (src_addr),
        .src_used     (src_used),
        .stall        (stall),
        .fwd_sel      (fwd_sel),
        .stage_valid  (stage_valid),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .fwd_events   (fwd_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what each stage holds, index 1 = EX ... NST = WB.
    logic          m_valid [1:NST];
    logic [AW-1:0] m_rd    [1:NST];
    logic          m_regwr [1:NST];
    logic          m_memrd [1:NST];
    logic          m_rpz   [1:NST];
    logic          e_stall;
    logic          e_any;
    int            e_sel   [NSRC];
`ifdef HAZARD_PERF_CNT_EN
    int unsigned   m_stall_cnt;
    int unsigned   m_fwd_cnt;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int k = 1; k <= NST; k++) begin
            m_valid[k] = 0; m_rd[k] = '0; m_regwr[k] = 0; m_memrd[k] = 0; m_rpz[k] = 0;
        end
`ifdef HAZARD_PERF_CNT_EN
        m_stall_cnt = 0;
        m_fwd_cnt   = 0;
`endif
    endfunction

    // Youngest real writer of the operand's register, or 0.
    function automatic int model_sel(input int i);
        logic [AW-1:0] a;
        a = src_addr[i*AW +: AW];
        if (!src_used[i] || a == 0) return 0;
        for (int k = 1; k <= NST; k++)
            if (m_valid[k] && m_regwr[k] && !m_rpz[k] && m_rd[k] == a) return k;
        return 0;
    endfunction

    task automatic sample();
        logic [NST-1:0] ev;
        logic           ewe;
        @(negedge clk);
        e_stall = 0;
        e_any   = 0;
        for (int i = 0; i < NSRC; i++) begin
            e_sel[i] = model_sel(i);
            if (e_sel[i] != 0) e_any = 1;
            if (issue_valid && e_sel[i] != 0 && m_memrd[e_sel[i]] && e_sel[i] < LDS) e_stall = 1;
            chk($sformatf("fwd_sel[%0d]", i), 32'(fwd_sel[i*SW +: SW]), 32'(e_sel[i]));
        end
        chk("stall", 32'(stall), 32'(e_stall));
        for (int k = 1; k <= NST; k++) ev[k-1] = m_valid[k];
        chk("stage_valid", 32'(stage_valid), 32'(ev));
        ewe = m_valid[NST] && m_regwr[NST] && !m_rpz[NST] && m_rd[NST] != 0;
        chk("wb_we", 32'(wb_we), 32'(ewe));
        chk("wb_rd", 32'(wb_rd), 32'(m_rd[NST]));
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, m_stall_cnt);
        chk("fwd_events", fwd_events, m_fwd_cnt);
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        for (int k = NST; k >= 2; k--) begin
            m_valid[k] = m_valid[k-1]; m_rd[k] = m_rd[k-1]; m_regwr[k] = m_regwr[k-1];
            m_memrd[k] = m_memrd[k-1]; m_rpz[k] = m_rpz[k-1];
        end
        if (issue_valid && !e_stall) begin
            m_valid[1] = 1; m_rd[1] = issue_rd; m_regwr[1] = issue_regwr;
            m_memrd[1] = issue_memrd; m_rpz[1] = issue_rpzero;
        end else begin
            m_valid[1] = 0; m_rd[1] = '0; m_regwr[1] = 0; m_memrd[1] = 0; m_rpz[1] = 0;
        end
`ifdef HAZARD_PERF_CNT_EN
        if (e_stall) m_stall_cnt++;
        if (issue_valid && !e_stall && e_any) m_fwd_cnt++;
`endif
        #1;
    endtask

    task automatic iss(input logic v, input int rd, input logic rw, input logic mr, input logic rpz);
        issue_valid  = v;
        issue_rd     = AW'(rd);
        issue_regwr  = rw;
        issue_memrd  = mr;
        issue_rpzero = rpz;
        src_used     = '0;
        src_addr     = '0;
    endtask

    task automatic src(input int i, input int a);
        src_addr[i*AW +: AW] = AW'(a);
        src_used[i]          = 1'b1;
    endtask

    task automatic nops(input int n);
        for (int j = 0; j < n; j++) begin
            iss(0, 0, 0, 0, 0);
            sample();
            advance();
        end
    endtask

    function automatic int pick_reg();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 3;
            4: return 31;
            default: return int'($urandom_range(0, 31));
        endcase
    endfunction

    function automatic int sel_of(input int i);
        logic [SW-1:0] s;
        s = fwd_sel[i*SW +: SW];
        return int'(s);
    endfunction

    initial begin
        rst_sync = 1'b1;
        iss(0, 0, 0, 0, 0);
        model_clear();
        e_stall = 0;
        #2;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_stage_valid", 32'(stage_valid), 32'd0);
        chk("reset_wb_we", 32'(wb_we), 32'd0);
        chk("reset_wb_rd", 32'(wb_rd), 32'd0);
        chk("reset_fwd_sel", 32'(fwd_sel), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("reset_stall_cycles", stall_cycles, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_sync = 1'b0;

        // Load-use: one stall cycle, bubble into EX, then forward from MEM.
        iss(1, 5, 1, 1, 0);                       sample(); advance();
        iss(1, 6, 1, 0, 0); src(0, 5); src(1, 2); sample();
        chk("lu_stall", 32'(stall), 32'd1);
        advance();
        sample();
        chk("lu_stall_clear", 32'(stall), 32'd0);
        chk("lu_bubble", 32'(stage_valid[0]), 32'd0);
        chk("lu_fwd", 32'(sel_of(0)), 32'd2);
`ifdef HAZARD_PERF_CNT_EN
        chk("lu_stall_cycles", stall_cycles, 32'd1);
`endif
        advance();
        nops(3);

        // ALU forward from EX, then WB, then nothing once retired.
        iss(1, 3, 1, 0, 0);                       sample(); advance();
        iss(1, 10, 1, 0, 0); src(0, 3);           sample();
        chk("alu_fwd1", 32'(sel_of(0)), 32'd1);
        chk("alu_nostall", 32'(stall), 32'd0);
        advance();
        nops(1);
        iss(1, 11, 1, 0, 0); src(1, 3);           sample();
        chk("alu_fwd3", 32'(sel_of(1)), 32'd3);
        advance();
        iss(1, 12, 1, 0, 0); src(2, 3);           sample();
        chk("alu_fwd0", 32'(sel_of(2)), 32'd0);
        advance();
        nops(3);

        // Predicated-false younger write is skipped; it never writes back.
        iss(1, 4, 1, 0, 0);                       sample(); advance();
        nops(1);
        iss(1, 4, 1, 0, 1);                       sample(); advance();
        iss(1, 9, 1, 0, 0); src(0, 4);            sample();
        chk("pred_fwd", 32'(sel_of(0)), 32'd3);
        advance();
        nops(1);
        sample();
        chk("pred_wb_we", 32'(wb_we), 32'd0);
        advance();
        nops(3);

        // r0 never forwards nor writes; r31 writes normally.
        iss(1, 0, 1, 0, 0);                       sample(); advance();
        iss(1, 31, 1, 0, 0); src(0, 0);           sample();
        chk("r0_fwd", 32'(sel_of(0)), 32'd0);
        chk("r0_nostall", 32'(stall), 32'd0);
        advance();
        nops(1);
        sample();
        chk("r0_wb_we", 32'(wb_we), 32'd0);
        advance();
        iss(0, 0, 0, 0, 0);                       sample();
        chk("r31_wb_we", 32'(wb_we), 32'd1);
        chk("r31_wb_rd", 32'(wb_rd), 32'd31);
        advance();
        nops(3);

        // Two producers of r7: youngest wins; a young load stalls.
        iss(1, 7, 1, 0, 0);                       sample(); advance();
        iss(1, 7, 1, 0, 0);                       sample(); advance();
        iss(1, 8, 1, 0, 0); src(0, 7);            sample();
        chk("r7_young", 32'(sel_of(0)), 32'd1);
        advance();
        nops(3);
        iss(1, 7, 1, 0, 0);                       sample(); advance();
        iss(1, 7, 1, 1, 0);                       sample(); advance();
        iss(1, 8, 1, 0, 0); src(0, 7);            sample();
        chk("r7_load_stall", 32'(stall), 32'd1);
        advance();
        nops(3);

        // Asynchronous reset in the middle of a load stall.
        iss(1, 5, 1, 1, 0);                       sample(); advance();
        iss(1, 6, 1, 0, 0); src(2, 5);            sample();
        chk("rst_pre_stall", 32'(stall), 32'd1);
        rst_sync = 1'b1;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_stage_valid", 32'(stage_valid), 32'd0);
        model_clear();
        e_stall = 0;
        @(posedge clk);
        #1;
        rst_sync = 1'b0;

        // Random traffic; a stalled instruction is re-presented unchanged.
        for (int n = 0; n < 1500; n++) begin
            if (!e_stall) begin
                iss(($urandom_range(0, 9) < 8), pick_reg(), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0));
                for (int i = 0; i < NSRC; i++)
                    if ($urandom_range(0, 2) != 0) src(i, pick_reg());
            end
            sample();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
